// File: rtl/shift_acc_pkg.sv
// Shared types and saturating-add helpers for the shift accumulator array.
package shift_acc_pkg;

  localparam int unsigned MAX_W         = 64;
  localparam int unsigned DEF_STAGE_NUM = 16;
  localparam int unsigned DEF_DEPTH_W   = $clog2(DEF_STAGE_NUM);

  typedef logic [DEF_DEPTH_W-1:0] depth_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] value;
  } sat_res_t;

  // Largest / smallest representable value of a signed field of the given width.
  function automatic logic signed [MAX_W-1:0] acc_max(input int unsigned width);
    return (MAX_W'(1) <<< (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic signed [MAX_W-1:0] acc_min(input int unsigned width);
    return ~acc_max(width);
  endfunction

  // Add two sign-extended operands and clamp into a width-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int unsigned             width);
    sat_res_t                res;
    logic signed [MAX_W-1:0] sum;
    sum       = a + b;
    res.ovf   = 1'b0;
    res.value = sum;
    if (sum > acc_max(width)) begin
      res.ovf   = 1'b1;
      res.value = acc_max(width);
    end else if (sum < acc_min(width)) begin
      res.ovf   = 1'b1;
      res.value = acc_min(width);
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_acc_lane.sv
// One accumulation chain: shift register, head adder, optional clamp + sticky flag.
// Saturation is enabled by defining SHIFT_ACC_SAT_EN.
module shift_acc_lane
  import shift_acc_pkg::*;
#(
  parameter int unsigned STAGE_NUM = 16,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DEPTH_W   = $clog2(STAGE_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic                        clear,
  input  logic                        is_init,
`ifdef SHIFT_ACC_SAT_EN
  input  logic                        done_load,
  output logic                        sat_c,
`endif
  input  logic [DEPTH_W-1:0]          depth,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [ACC_WIDTH-1:0] head_c
);

  logic signed [ACC_WIDTH-1:0] entry [STAGE_NUM];

`ifdef SHIFT_ACC_SAT_EN
  sat_res_t sum_res;
  logic     sticky;

  // Init beats cannot clamp and start a fresh sticky history.
  always_comb begin
    sum_res = sat_add(MAX_W'(entry[depth]), MAX_W'(din), ACC_WIDTH);
    head_c  = is_init ? ACC_WIDTH'(din) : ACC_WIDTH'(sum_res.value);
    sat_c   = !is_init && (sticky || sum_res.ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sticky <= 1'b0;
    else if (clear)    sticky <= 1'b0;
    else if (shift_en) sticky <= done_load ? 1'b0 : sat_c;
  end
`else
  always_comb begin
    head_c = is_init ? ACC_WIDTH'(din) : entry[depth] + ACC_WIDTH'(din);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGE_NUM); i++) entry[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(STAGE_NUM); i++) entry[i] <= '0;
    end else if (shift_en) begin
      for (int i = int'(STAGE_NUM) - 1; i > 0; i--) entry[i] <= entry[i-1];
      entry[0] <= head_c;
    end
  end

endmodule

// File: rtl/shift_accumulator_array.sv
// LANES parallel shift-accumulator chains sharing one control stream, with a
// one-entry valid/ready result register. Optional saturation: SHIFT_ACC_SAT_EN.
module shift_accumulator_array
  import shift_acc_pkg::*;
#(
  parameter int unsigned LANES     = 8,
  parameter int unsigned STAGE_NUM = 16,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DEPTH_W   = $clog2(STAGE_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANES*IN_WIDTH-1:0]    data_i,
  input  logic                         is_init_data_i,
  input  logic                         calc_done_i,
  input  logic [DEPTH_W-1:0]           valid_depth_i,
  input  logic                         clear_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [LANES*ACC_WIDTH-1:0]   data_o,
  output logic [LANES-1:0]             sat_flag_o
);

  logic                       accept_c;
  logic                       done_load_c;
  logic [LANES*ACC_WIDTH-1:0] head_c;

  // Clear wins over any beat presented in the same cycle.
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept_c    = in_valid_i && in_ready_o && !clear_i;
  assign done_load_c = accept_c && calc_done_i;

`ifdef SHIFT_ACC_SAT_EN
  logic [LANES-1:0] sat_c;
`endif

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    shift_acc_lane #(
      .STAGE_NUM (STAGE_NUM),
      .IN_WIDTH  (IN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .DEPTH_W   (DEPTH_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (accept_c),
      .clear     (clear_i),
      .is_init   (is_init_data_i),
`ifdef SHIFT_ACC_SAT_EN
      .done_load (done_load_c),
      .sat_c     (sat_c[k]),
`endif
      .depth     (valid_depth_i),
      .din       (data_i[k*IN_WIDTH +: IN_WIDTH]),
      .head_c    (head_c[k*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  // A new done load takes priority over the consumer draining the old result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      data_o      <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      data_o      <= '0;
    end else if (done_load_c) begin
      out_valid_o <= 1'b1;
      data_o      <= head_c;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef SHIFT_ACC_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sat_flag_o <= '0;
    else if (clear_i)     sat_flag_o <= '0;
    else if (done_load_c) sat_flag_o <= sat_c;
  end
`else
  assign sat_flag_o = '0;
`endif

endmodule

// File: tb/tb_shift_accumulator_array.sv
// Directed self-checking bench for shift_accumulator_array (2 lanes, 4 stages,
// 8-bit accumulators plus a 16-bit-accumulator twin sharing the stimulus).
module tb_shift_accumulator_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, is_init, calc_done, clear, out_ready;
  logic [15:0] data;
  logic [1:0]  depth;

  logic        in_ready, out_valid;
  logic [15:0] data_out;
  logic [1:0]  sat_flag;

  logic        in_ready_w, out_valid_w;
  logic [31:0] data_out_w;
  logic [1:0]  sat_flag_w;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_accumulator_array #(
    .LANES(2), .STAGE_NUM(4), .IN_WIDTH(8), .ACC_WIDTH(8), .DEPTH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data), .is_init_data_i(is_init), .calc_done_i(calc_done),
    .valid_depth_i(depth), .clear_i(clear), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_o(data_out), .sat_flag_o(sat_flag)
  );

  shift_accumulator_array #(
    .LANES(2), .STAGE_NUM(4), .IN_WIDTH(8), .ACC_WIDTH(16), .DEPTH_W(2)
  ) dut_w (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_w),
    .data_i(data), .is_init_data_i(is_init), .calc_done_i(calc_done),
    .valid_depth_i(depth), .clear_i(clear), .out_valid_o(out_valid_w),
    .out_ready_i(out_ready), .data_o(data_out_w), .sat_flag_o(sat_flag_w)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One accepted beat; returns at posedge+1 with in_valid dropped.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic init, input logic done);
    int n;
    @(negedge clk);
    data = {b, a}; is_init = init; calc_done = done; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; is_init = 1'b0; calc_done = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; is_init = 1'b0; calc_done = 1'b0;
    clear = 1'b0; out_ready = 1'b1; data = '0; depth = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    vectors++;
    if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", data_out); end
    vectors++;
    if (sat_flag !== 2'b00) begin errors++; $display("FAIL reset_sat: got %b required 00", sat_flag); end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    depth = 2'd0; out_ready = 1'b1;
    drive_beat(8'd5, 8'hFD, 1'b1, 1'b0);
    drive_beat(8'd1, 8'd1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
    drive_beat(8'd2, 8'd2, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    vectors++;
    if (data_out !== 16'h0008) begin errors++; $display("FAIL basic_data: got %h required 0008", data_out); end
    vectors++;
    if (data_out_w !== 32'h0000_0008) begin errors++; $display("FAIL basic_data_wide: got %h required 00000008", data_out_w); end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b required 0", out_valid); end
  endtask

  task automatic test_interleave();
    logic [7:0] a, b, ea, eb;
    int t;
    drain();
    depth = 2'd3;
    for (int j = 0; j < 16; j++) begin
      a = (j < 4) ? 8'(10 * (j + 1)) : 8'd1;
      b = (j < 4) ? 8'(-(j + 1)) : 8'd1;
      drive_beat(a, b, j < 4, j >= 12);
      if (j >= 12) begin
        t  = j - 12;
        ea = 8'(10 * (t + 1) + 3);
        eb = 8'(2 - t);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== {eb, ea}) begin
          errors++;
          $display("FAIL interleave_tile%0d: got valid=%b data=%h required valid=1 data=%h", t, out_valid, data_out, {eb, ea});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    drain();
    depth = 2'd0; out_ready = 1'b0;
    drive_beat(8'd7, 8'd9, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h0907) begin
      errors++; $display("FAIL bp_load: got valid=%b data=%h required valid=1 data=0907", out_valid, data_out);
    end
    @(negedge clk);
    data = {8'd1, 8'd1}; is_init = 1'b0; calc_done = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0 || data_out !== 16'h0907) begin
        errors++; $display("FAIL bp_stall%0d: got ready=%b data=%h required ready=0 data=0907", c, in_ready, data_out);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; calc_done = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h0A08) begin
      errors++; $display("FAIL bp_release: got valid=%b data=%h required valid=1 data=0a08", out_valid, data_out);
    end
  endtask

  task automatic test_sat();
    logic [15:0] exp_d;
    logic [1:0]  exp_f;
    depth = 2'd0; out_ready = 1'b1;
    drive_beat(8'd100, 8'd1, 1'b1, 1'b0);
    drive_beat(8'd100, 8'd1, 1'b0, 1'b0);
    drive_beat(8'h9C, 8'd1, 1'b0, 1'b1);
`ifdef SHIFT_ACC_SAT_EN
    exp_d = {8'd3, 8'd27};
    exp_f = 2'b01;
`else
    exp_d = {8'd3, 8'd100};
    exp_f = 2'b00;
`endif
    vectors++;
    if (data_out !== exp_d) begin errors++; $display("FAIL sat_data: got %h required %h", data_out, exp_d); end
    vectors++;
    if (sat_flag !== exp_f) begin errors++; $display("FAIL sat_flag: got %b required %b", sat_flag, exp_f); end
    vectors++;
    if (data_out_w !== 32'h0003_0064) begin errors++; $display("FAIL sat_data_wide: got %h required 00030064", data_out_w); end
    vectors++;
    if (sat_flag_w !== 2'b00) begin errors++; $display("FAIL sat_flag_wide: got %b required 00", sat_flag_w); end
    drive_beat(8'd3, 8'd4, 1'b1, 1'b1);
    vectors++;
    if (data_out !== 16'h0403 || sat_flag !== 2'b00) begin
      errors++; $display("FAIL sat_next_tile: got data=%h flag=%b required data=0403 flag=00", data_out, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    depth = 2'd0; out_ready = 1'b1;
    drive_beat(8'd11, 8'd12, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h0C0B) begin
      errors++; $display("FAIL b2b_first: got valid=%b data=%h required valid=1 data=0c0b", out_valid, data_out);
    end
    drive_beat(8'd10, 8'd10, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h1615) begin
      errors++; $display("FAIL b2b_second: got valid=%b data=%h required valid=1 data=1615", out_valid, data_out);
    end
  endtask

  task automatic test_clear();
    drain();
    depth = 2'd0; out_ready = 1'b0;
    drive_beat(8'd40, 8'd50, 1'b1, 1'b1);
    @(negedge clk);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    data = {8'd1, 8'd1}; is_init = 1'b0; calc_done = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; calc_done = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || data_out !== 16'h0000) begin
      errors++; $display("FAIL clear_flush: got valid=%b data=%h required valid=0 data=0000", out_valid, data_out);
    end
    drive_beat(8'd7, 8'd7, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h0707 || sat_flag !== 2'b00) begin
      errors++; $display("FAIL clear_residue: got valid=%b data=%h flag=%b required valid=1 data=0707 flag=00", out_valid, data_out, sat_flag);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    depth = 2'd0; out_ready = 1'b0;
    drive_beat(8'd40, 8'd50, 1'b1, 1'b0);
    drive_beat(8'd1, 8'd1, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h3329) begin
      errors++; $display("FAIL rst_pre: got valid=%b data=%h required valid=1 data=3329", out_valid, data_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || data_out !== 16'h0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async: got valid=%b data=%h ready=%b required valid=0 data=0000 ready=1", out_valid, data_out, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    drive_beat(8'd7, 8'd7, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || data_out !== 16'h0707) begin
      errors++; $display("FAIL rst_residue: got valid=%b data=%h required valid=1 data=0707", out_valid, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_backpressure();
    test_sat();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
